arb8_rr: RTL and testbench

Eight-requester round-robin arbiter that shares one downstream resource (bus, register-file write port, or ALU slot) between up to eight clients. Request presence is reduced with an 8-input OR. Grants are registered, one-hot and fair, with a bounded hold time so a single client cannot starve the others. It sits between the client request lines and the shared resource's select/enable inputs.

---
 rtl/arb8_rr.sv | 110 +++++++++++
 tb/tb_arb8_rr.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/arb8_rr.sv
// Eight-client round-robin arbiter with registered one-hot grant and a bounded
// hold time so a contended owner is rotated out after HOLD_MAX cycles.
module arb8_rr #(
  parameter int HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       busy,
  output logic       any_req
);

  localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state, state_nxt;
  logic [2:0] last, last_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [7:0] gnt_nxt;
  logic [2:0] gnt_id_nxt;
  logic       busy_nxt;
  logic [3:0] pick;
  logic       contended;

  // Returns {found, index} of the first requester scanning start, start+1, ...
  // Walking the offsets backwards lets the lowest offset overwrite the rest.
  function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] start);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      idx = start + 3'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign any_req = |req;

  // The owner is always LAST, so every search starts one past it.
  assign pick      = rr_pick(req, last + 3'd1);
  assign contended = (req & ~(8'd1 << last)) != 8'd0;

  always_comb begin
    state_nxt  = state;
    last_nxt   = last;
    cnt_nxt    = cnt;
    gnt_nxt    = gnt;
    gnt_id_nxt = gnt_id;
    busy_nxt   = busy;
    unique case (state)
      IDLE: begin
        if (pick[3]) begin
          state_nxt  = GRANT;
          last_nxt   = pick[2:0];
          cnt_nxt    = 8'd1;
          gnt_nxt    = 8'd1 << pick[2:0];
          gnt_id_nxt = pick[2:0];
          busy_nxt   = 1'b1;
        end else begin
          gnt_nxt    = 8'd0;
          gnt_id_nxt = 3'd0;
          busy_nxt   = 1'b0;
        end
      end
      GRANT: begin
        if (!req[last] || ((cnt >= HOLD_LIM) && contended)) begin
          if (pick[3]) begin
            last_nxt   = pick[2:0];
            cnt_nxt    = 8'd1;
            gnt_nxt    = 8'd1 << pick[2:0];
            gnt_id_nxt = pick[2:0];
            busy_nxt   = 1'b1;
          end else begin
            state_nxt  = IDLE;
            cnt_nxt    = 8'd0;
            gnt_nxt    = 8'd0;
            gnt_id_nxt = 3'd0;
            busy_nxt   = 1'b0;
          end
        end else begin
          cnt_nxt = (cnt >= HOLD_LIM) ? HOLD_LIM : cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      last   <= 3'd7;
      cnt    <= 8'd0;
      gnt    <= 8'd0;
      gnt_id <= 3'd0;
      busy   <= 1'b0;
    end else begin
      state  <= state_nxt;
      last   <= last_nxt;
      cnt    <= cnt_nxt;
      gnt    <= gnt_nxt;
      gnt_id <= gnt_id_nxt;
      busy   <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_arb8_rr.sv
// Bench for arb8_rr: directed scenarios with literal expectations, then random
// request traffic compared every cycle against an owner/hold-count model.
module tb_arb8_rr;

  localparam int H = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       busy;
  logic       any_req;

  int checks   = 0;
  int failures = 0;

  arb8_rr #(.HOLD_MAX(H)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .any_req(any_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: owner index (-1 when idle), last winner, and cycles held so far.
  int m_owner = -1;
  int m_last  = 7;
  int m_held  = 0;
  int n_owner, n_last, n_held, w;

  function automatic int rr_search(input logic [7:0] r, input int from);
    for (int k = 0; k < 8; k++) begin
      if (r[(from + k) % 8]) return (from + k) % 8;
    end
    return -1;
  endfunction

  always_comb begin
    n_owner = m_owner;
    n_last  = m_last;
    n_held  = m_held;
    w       = -1;
    if (m_owner < 0) begin
      w = rr_search(req, m_last + 1);
    end else if (!req[m_owner]) begin
      w = rr_search(req, m_owner + 1);
      if (w < 0) n_owner = -1;
    end else if (m_held >= H && (req & ~(8'd1 << m_owner)) != 8'd0) begin
      w = rr_search(req, m_owner + 1);
    end else begin
      n_held = m_held + 1;
    end
    if (w >= 0) begin
      n_owner = w;
      n_last  = w;
      n_held  = 1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner <= -1;
      m_last  <= 7;
      m_held  <= 0;
    end else begin
      m_owner <= n_owner;
      m_last  <= n_last;
      m_held  <= n_held;
    end
  end

  logic [7:0] exp_gnt;
  logic [2:0] exp_id;
  assign exp_gnt = (m_owner >= 0) ? (8'd1 << m_owner) : 8'd0;
  assign exp_id  = (m_owner >= 0) ? 3'(m_owner) : 3'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("cyc_gnt", 32'(gnt), 32'(exp_gnt));
    check("cyc_gnt_id", 32'(gnt_id), 32'(exp_id));
    check("cyc_busy", 32'(busy), 32'(exp_gnt != 8'd0));
    check("cyc_any_req", 32'(any_req), 32'(|req));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] r;

  initial begin
    rst_n = 1'b0;
    req   = 8'h04;
    #3;
    check("rst_gnt", 32'(gnt), 32'h00);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_any_req", 32'(any_req), 32'h1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Single request
    tick();
    check("single_gnt", 32'(gnt), 32'h04);
    check("single_id", 32'(gnt_id), 32'd2);
    check("single_busy", 32'(busy), 32'h1);
    req = 8'h00;
    tick();
    check("single_rel_gnt", 32'(gnt), 32'h00);
    check("single_rel_busy", 32'(busy), 32'h0);

    // Full contention from a fresh reset
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    req = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      for (int c = 0; c < H; c++) begin
        tick();
        check("rot_gnt", 32'(gnt), 32'(8'd1 << (g % 8)));
        check("rot_id", 32'(gnt_id), 32'(g % 8));
      end
    end

    // Wrap priority: owner 6 releases, client 0 waiting
    req = 8'h40;
    tick();
    check("wrap_own6", 32'(gnt), 32'h40);
    req = 8'h01;
    tick();
    check("wrap_gnt", 32'(gnt), 32'h01);
    check("wrap_busy", 32'(busy), 32'h1);

    // Uncontended hold, then late requester preempts a saturated owner
    req = 8'h08;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("hold_gnt", 32'(gnt), 32'h08);
    end
    req = 8'h0A;
    tick();
    check("preempt_gnt", 32'(gnt), 32'h02);

    // Release with no waiters, then LAST=5 gives client 6 first
    req = 8'h20;
    tick();
    check("own5_gnt", 32'(gnt), 32'h20);
    req = 8'h00;
    tick();
    check("idle_gnt", 32'(gnt), 32'h00);
    check("idle_busy", 32'(busy), 32'h0);
    check("idle_id", 32'(gnt_id), 32'd0);
    req = 8'hFF;
    tick();
    check("after5_gnt", 32'(gnt), 32'h40);

    // Async reset while client 4 owns the grant
    req = 8'h10;
    tick();
    check("own4_gnt", 32'(gnt), 32'h10);
    req = 8'hFF;
    #2 rst_n = 1'b0;
    #1;
    check("async_gnt", 32'(gnt), 32'h00);
    check("async_busy", 32'(busy), 32'h0);
    check("async_id", 32'(gnt_id), 32'd0);
    #2 rst_n = 1'b1;
    tick();
    check("post_rst_gnt", 32'(gnt), 32'h01);

    // Random traffic
    r = 8'h00;
    for (int i = 0; i < 2000; i++) begin
      case ($urandom_range(0, 3))
        0: r = 8'($urandom);
        1: r = r ^ (8'd1 << $urandom_range(0, 7));
        2: r = 8'hFF;
        default: r = 8'($urandom) & 8'($urandom);
      endcase
      req = r;
      if ($urandom_range(0, 199) == 0) begin
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      tick();
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
